// File: rtl/posit_stft_pkg.sv
// Shared definitions for the posit STFT datapath: posit constants and the
// complex-multiply issue controller state encoding.
package posit_stft_pkg;

    localparam int POSIT_W = 32;
    localparam logic [POSIT_W-1:0] POSIT_NAR = 32'h8000_0000;
    localparam logic [POSIT_W-1:0] POSIT_ONE = 32'h4000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_CALC  = 3'd3,
        ST_OUT   = 3'd4
    } cmul_state_e;

endpackage

// File: rtl/cmul_wdog.sv
// Watchdog for the multiplier: counts enabled cycles and flags the cycle that
// is the TIMEOUT-th one since the last clear.
module cmul_wdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    // Counts completed cycles, so the current cycle is number cnt_q+1.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/cmul_issue_ctrl.sv
// Issue controller: pairs each input sample with its twiddle, hands both to an
// external complex posit multiplier and returns the product, one at a time.
module cmul_issue_ctrl
    import posit_stft_pkg::*;
#(
    parameter int N_POINTS = 16,
    parameter int TIMEOUT  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; the sender holds data stable until then.
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [POSIT_W-1:0]          s_re,
    input  logic [POSIT_W-1:0]          s_im,
    output logic [$clog2(N_POINTS)-1:0] tw_addr,
    output logic                        tw_en,
    input  logic [POSIT_W-1:0]          tw_re,
    input  logic [POSIT_W-1:0]          tw_im,
    output logic                        cmul_valid_in,
    output logic [POSIT_W-1:0]          cmul_re1,
    output logic [POSIT_W-1:0]          cmul_im1,
    output logic [POSIT_W-1:0]          cmul_re2,
    output logic [POSIT_W-1:0]          cmul_im2,
    input  logic [POSIT_W-1:0]          cmul_re_out,
    input  logic [POSIT_W-1:0]          cmul_im_out,
    input  logic                        cmul_valid_out,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [POSIT_W-1:0]          m_re,
    output logic [POSIT_W-1:0]          m_im,
    output logic                        m_last,
    output logic                        err,
    output cmul_state_e                 dbg_state
);

    localparam int AW = $clog2(N_POINTS);

    cmul_state_e        state_q;
    logic [AW-1:0]      idx_q;
    logic [AW-1:0]      idx_d;
    logic [POSIT_W-1:0] smp_re_q, smp_im_q;
    logic               s_ready_q, tw_en_q, cmul_valid_in_q;
    logic [AW-1:0]      tw_addr_q;
    logic [POSIT_W-1:0] op_re1_q, op_im1_q, op_re2_q, op_im2_q;
    logic               m_valid_q, m_last_q, err_q;
    logic [POSIT_W-1:0] m_re_q, m_im_q;
    logic               in_calc;
    logic               wd_expired;

    assign in_calc = (state_q == ST_CALC);
    assign idx_d   = (idx_q == AW'(N_POINTS - 1)) ? '0 : idx_q + AW'(1);

    cmul_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (in_calc),
        .clear   (!in_calc),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            smp_re_q        <= '0;
            smp_im_q        <= '0;
            s_ready_q       <= 1'b0;
            tw_en_q         <= 1'b0;
            tw_addr_q       <= '0;
            cmul_valid_in_q <= 1'b0;
            op_re1_q        <= '0;
            op_im1_q        <= '0;
            op_re2_q        <= '0;
            op_im2_q        <= '0;
            m_valid_q       <= 1'b0;
            m_last_q        <= 1'b0;
            m_re_q          <= '0;
            m_im_q          <= '0;
            err_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        smp_re_q  <= s_re;
                        smp_im_q  <= s_im;
                        s_ready_q <= 1'b0;
                        tw_en_q   <= 1'b1;
                        tw_addr_q <= idx_q;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    tw_en_q <= 1'b0;
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    // Operands only change here so they are stable for all of CALC.
                    op_re1_q        <= smp_re_q;
                    op_im1_q        <= smp_im_q;
                    op_re2_q        <= tw_re;
                    op_im2_q        <= tw_im;
                    cmul_valid_in_q <= 1'b1;
                    state_q         <= ST_CALC;
                end
                ST_CALC: begin
                    if (cmul_valid_out || wd_expired) begin
                        cmul_valid_in_q <= 1'b0;
                        m_valid_q       <= 1'b1;
                        m_last_q        <= (idx_q == AW'(N_POINTS - 1));
                        state_q         <= ST_OUT;
                        if (cmul_valid_out) begin
                            m_re_q <= cmul_re_out;
                            m_im_q <= cmul_im_out;
                        end else begin
                            m_re_q <= POSIT_NAR;
                            m_im_q <= POSIT_NAR;
                            err_q  <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        idx_q     <= idx_d;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready       = s_ready_q;
    assign tw_en         = tw_en_q;
    assign tw_addr       = tw_addr_q;
    assign cmul_valid_in = cmul_valid_in_q;
    assign cmul_re1      = op_re1_q;
    assign cmul_im1      = op_im1_q;
    assign cmul_re2      = op_re2_q;
    assign cmul_im2      = op_im2_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign m_re          = m_re_q;
    assign m_im          = m_im_q;
    assign err           = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cmul_issue_ctrl.sv
// Bench for cmul_issue_ctrl: twiddle ROM alternating 1+j0 / 0+j1 and a
// one-cycle multiplier stub that is exact for those two rotations.
module tb_cmul_issue_ctrl;
  import posit_stft_pkg::*;

  localparam int N  = 16;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_re = '0;
  logic [31:0] s_im = '0;
  logic [3:0]  tw_addr;
  logic        tw_en;
  logic [31:0] tw_re = '0;
  logic [31:0] tw_im = '0;
  logic        cmul_valid_in;
  logic [31:0] cmul_re1, cmul_im1, cmul_re2, cmul_im2;
  logic [31:0] cmul_re_out = '0;
  logic [31:0] cmul_im_out = '0;
  logic        cmul_valid_out = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_re, m_im;
  logic        m_last;
  logic        err;
  cmul_state_e dbg_state;

  cmul_issue_ctrl #(.N_POINTS(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_re           (s_re),
    .s_im           (s_im),
    .tw_addr        (tw_addr),
    .tw_en          (tw_en),
    .tw_re          (tw_re),
    .tw_im          (tw_im),
    .cmul_valid_in  (cmul_valid_in),
    .cmul_re1       (cmul_re1),
    .cmul_im1       (cmul_im1),
    .cmul_re2       (cmul_re2),
    .cmul_im2       (cmul_im2),
    .cmul_re_out    (cmul_re_out),
    .cmul_im_out    (cmul_im_out),
    .cmul_valid_out (cmul_valid_out),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_re           (m_re),
    .m_im           (m_im),
    .m_last         (m_last),
    .err            (err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- environment models ----------------
  bit mul_on = 1'b1;

  always @(posedge clk) begin
    if (tw_en) begin
      tw_re <= tw_addr[0] ? 32'h0 : POSIT_ONE;
      tw_im <= tw_addr[0] ? POSIT_ONE : 32'h0;
    end
  end

  always @(posedge clk) begin
    cmul_valid_out <= mul_on && cmul_valid_in;
    if (cmul_re2 == POSIT_ONE && cmul_im2 == 32'h0) begin
      cmul_re_out <= cmul_re1;
      cmul_im_out <= cmul_im1;
    end else if (cmul_re2 == 32'h0 && cmul_im2 == POSIT_ONE) begin
      cmul_re_out <= 32'h0 - cmul_im1;
      cmul_im_out <= cmul_re1;
    end else begin
      cmul_re_out <= 32'hDEAD_BEEF;
      cmul_im_out <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_idx = 0;
  int cur_idx = 0;
  logic [31:0] cur_re1 = '0, cur_im1 = '0, cur_re2 = '0, cur_im2 = '0;
  int tw_cnt = 0;
  int n_results = 0;
  int n_last = 0;
  int last_tw_addr = -1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] re, input logic [31:0] im, input int idx);
    logic last;
    last = (idx == N - 1);
    if (idx % 2 == 0) return {last, re, im};
    return {last, 32'h0 - im, re};
  endfunction

  task automatic push_sample(input logic [31:0] re, input logic [31:0] im);
    cur_idx = exp_idx;
    cur_re1 = re;
    cur_im1 = im;
    cur_re2 = (exp_idx % 2 == 0) ? POSIT_ONE : 32'h0;
    cur_im2 = (exp_idx % 2 == 0) ? 32'h0 : POSIT_ONE;
    tw_cnt  = 0;
    if (mul_on) exp_q.push_back(model(re, im, exp_idx));
    else exp_q.push_back({exp_idx == N - 1, POSIT_NAR, POSIT_NAR});
    exp_idx = (exp_idx + 1) % N;
  endtask

  always @(negedge clk) begin
    logic [64:0] e;
    if (tw_en) begin
      tw_cnt++;
      last_tw_addr = int'(tw_addr);
      check("tw_addr", 128'(tw_addr), 128'(cur_idx));
    end
    if (cmul_valid_in)
      check("operands", {cmul_re1, cmul_im1, cmul_re2, cmul_im2},
            {cur_re1, cur_im1, cur_re2, cur_im2});
    if (!m_valid) check("m_last_idle", 128'(m_last), 128'(0));
    if (m_valid || cmul_valid_in || tw_en) check("s_ready_busy", 128'(s_ready), 128'(0));
    if (m_valid && m_ready && rst_n) begin
      check("result_pending", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 128'({m_last, m_re, m_im}), 128'(e));
        check("tw_en_pulses", 128'(tw_cnt), 128'(1));
        n_results++;
        if (m_last) n_last++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [31:0] re, input logic [31:0] im);
    int w = 0;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("s_ready_wait", 128'(s_ready), 128'(1));
    if (s_ready) begin
      s_valid = 1'b1;
      s_re = re;
      s_im = im;
      @(posedge clk);
      push_sample(re, im);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || !s_ready) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream_held(input int n);
    int sent = 0;
    int guard = 0;
    bit hs;
    @(negedge clk);
    s_valid = 1'b1;
    s_re = $urandom;
    s_im = $urandom;
    while (sent < n && guard < 2000) begin
      hs = s_ready;
      @(posedge clk);
      if (hs) begin
        push_sample(s_re, s_im);
        sent++;
      end
      #1;
      if (hs) begin
        s_re = $urandom;
        s_im = $urandom;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0;
    check("held_sent", 128'(sent), 128'(n));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, ncalc, w, base_res, base_last;

    repeat (2) @(negedge clk);
    check("rst_ctrl", 128'({s_ready, m_valid, m_last, tw_en, cmul_valid_in, err}), 128'(0));
    check("rst_tw_addr", 128'(tw_addr), 128'(0));
    check("rst_m_data", 128'({m_re, m_im}), 128'(0));
    check("rst_operands", {cmul_re1, cmul_im1, cmul_re2, cmul_im2}, 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst_n = 1'b1;
    #1;
    check("s_ready_before_edge", 128'(s_ready), 128'(0));
    @(posedge clk);
    #1;
    check("s_ready_after_rst", 128'(s_ready), 128'(1));

    // Unity twiddle, minimum latency.
    send_sample(POSIT_ONE, POSIT_ONE);
    lat = 0;
    while (!m_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(4));
    check("first_result", 128'({m_re, m_im}), 128'({POSIT_ONE, POSIT_ONE}));
    wait_drain();

    // Full frame plus one, from a fresh reset.
    do_reset();
    base_res = n_results;
    base_last = n_last;
    for (int i = 0; i < 17; i++) send_sample($urandom, $urandom);
    wait_drain();
    check("frame_results", 128'(n_results - base_res), 128'(17));
    check("frame_last_count", 128'(n_last - base_last), 128'(1));
    send_sample($urandom, $urandom);
    wait_drain();
    check("idx_after_17", 128'(last_tw_addr), 128'(1));

    // Multiplier never answers.
    mul_on = 1'b0;
    send_sample(32'h1234_5678, 32'h0BAD_F00D);
    ncalc = 0;
    w = 0;
    while (!m_valid && w < 100) begin
      @(negedge clk);
      if (cmul_valid_in) ncalc++;
      w++;
    end
    check("calc_cycles", 128'(ncalc), 128'(TO));
    check("nar_result", 128'({m_re, m_im}), 128'({POSIT_NAR, POSIT_NAR}));
    check("err_set", 128'(err), 128'(1));
    wait_drain();
    mul_on = 1'b1;
    send_sample($urandom, $urandom);
    send_sample($urandom, $urandom);
    wait_drain();
    check("err_sticky", 128'(err), 128'(1));

    // Downstream backpressure for 5 cycles.
    m_ready = 1'b0;
    send_sample(32'h3333_0001, 32'h5555_0002);
    w = 0;
    while (!m_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 128'({m_valid, m_last, m_re, m_im}), 128'({1'b1, exp_q[0]}));
      check("bp_s_ready", 128'(s_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();

    // Reset while the multiplier is being waited on.
    mul_on = 1'b0;
    send_sample(32'h7777_7777, 32'h1111_1111);
    w = 0;
    while (!cmul_valid_in && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_calc_valid_in", 128'(cmul_valid_in), 128'(0));
    check("rst_err_clear", 128'(err), 128'(0));
    exp_q.delete();
    exp_idx = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_m_valid", 128'(m_valid), 128'(0));
    end
    rst_n = 1'b1;
    mul_on = 1'b1;
    send_sample(32'h2222_2222, 32'h4444_4444);
    wait_drain();
    check("tw_addr_after_rst", 128'(last_tw_addr), 128'(0));

    // s_valid held high with random downstream readiness.
    base_res = n_results;
    stream_held(12);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_drain();
    check("held_results", 128'(n_results - base_res), 128'(12));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmul_issue_ctrl.md
CMUL_ISSUE_CTRL -- requirements
Module: cmul_issue_ctrl

Interface
REQ-001 SHALL have parameter N_POINTS, default 16, frame length in samples (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT, default 8, the maximum number of CALC cycles to wait for cmul_valid_out (1..255).
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_re, s_im  in  32 each  posit32 sample.
- tw_addr  out  log2(N_POINTS)  twiddle table address.
- tw_en  out  1  twiddle table read enable.
- tw_re, tw_im  in  32 each  twiddle data, valid the cycle after tw_en.
- cmul_valid_in  out  1  operands valid to the complex posit multiplier.
- cmul_re1, cmul_im1, cmul_re2, cmul_im2  out  32 each  multiplier operands: sample, then twiddle.
- cmul_re_out, cmul_im_out  in  32 each  multiplier result.
- cmul_valid_out  in  1  multiplier result valid.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_re, m_im  out  32 each  product result.
- m_last  out  1  result is the last of the frame (index N_POINTS-1).
- err  out  1  sticky flag: a multiplier timeout has occurred.

Function
REQ-004 SHALL implement the FSM IDLE -> FETCH -> LATCH -> CALC -> OUT -> IDLE.
REQ-005 SHALL assert s_ready only in IDLE; when s_valid&s_ready, SHALL register s_re/s_im and go to FETCH.
REQ-006 In FETCH, SHALL assert tw_en for exactly one cycle with tw_addr equal to the frame index idx, then go to LATCH.
REQ-007 In LATCH, SHALL register tw_re/tw_im, then go to CALC.
REQ-008 In CALC, SHALL hold cmul_valid_in=1 and keep all four operands stable. Operands SHALL be re1=sample re, im1=sample im, re2=twiddle re, im2=twiddle im.
REQ-009 In any CALC cycle with cmul_valid_out=1, SHALL capture cmul_re_out/cmul_im_out into m_re/m_im and go to OUT.
REQ-010 SHALL count CALC cycles. If the TIMEOUT-th CALC cycle ends with cmul_valid_out=0, SHALL load m_re=m_im=32'h80000000 (NaR), set err, and go to OUT.
REQ-011 cmul_valid_in SHALL be 0 and operands SHALL hold their last values outside CALC.
REQ-012 In OUT, SHALL hold m_valid=1 and keep m_re, m_im and m_last stable until m_ready=1. On that handshake SHALL return to IDLE.
REQ-013 m_last SHALL equal (idx==N_POINTS-1) while m_valid=1, and SHALL be 0 otherwise.
REQ-014 idx SHALL increment on each m handshake and wrap from N_POINTS-1 to 0. A timed-out result also advances idx.
REQ-015 Minimum latency SHALL be 4 cycles from the s handshake edge to m_valid=1, when cmul_valid_out is high in the first CALC cycle.
REQ-016 At most one sample SHALL be in flight. s_ready SHALL be 0 from FETCH through OUT.
REQ-017 err SHALL remain set until reset.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE and clear idx, the CALC cycle counter and err. It SHALL force outputs to s_ready=0, m_valid=0, m_last=0, tw_en=0, cmul_valid_in=0, and all data outputs and tw_addr to 0.
REQ-019 s_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-020 Reset asserted mid-operation SHALL discard the in-flight sample without emitting a result.

Structure
REQ-021 The following SHALL live in shared package posit_stft_pkg, not in this module:
- the FSM state enum;
- POSIT_W=32;
- POSIT_NAR=32'h80000000;
- POSIT_ONE=32'h40000000.
REQ-022 The timeout counter SHALL be the single sub-module cmul_wdog (inputs: enable, clear; output: expired).
REQ-023 The complex multiplier SHALL be instantiated outside this block.

Verification
REQ-024 Twiddle table holds 1.0+j0 (0x40000000/0x00000000) and the bench multiplier responds in 1 cycle; sample 0x40000000+j0x40000000 -> m_re=m_im=0x40000000, m_valid 4 cycles after accept.
REQ-025 Stream 17 samples with m_ready=1 -> tw_addr sequence 0..15,0; m_last=1 only on result 16 (idx 15); idx=1 after result 17.
REQ-026 Multiplier never asserts valid_out, TIMEOUT=8 -> exactly 8 CALC cycles; m_re=m_im=0x80000000; err=1 and stays 1 after later normal results.
REQ-027 m_ready held 0 for 5 cycles in OUT -> m_valid, m_re, m_im and m_last stable; s_ready=0 throughout; one result delivered.
REQ-028 rst_n pulsed low during CALC -> cmul_valid_in=0 at once; no m_valid; next sample uses tw_addr=0.
REQ-029 s_valid held high continuously -> s_ready pulses once per completed result; no sample lost or duplicated (scoreboard check).
